// File: rtl/bit_column_scheduler.sv
// bit_column_scheduler: walks each group's non-zero bit columns high to low, one shift offset per beat
module bit_column_scheduler #(
  parameter int COLS  = 7,
  parameter int OFF_W = 3,
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COLS-1:0]  in_index,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OFF_W-1:0] out_offset,
  output logic             out_last,
  output logic             out_empty,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [15:0]      stat_groups
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [COLS-1:0] mask, mask_nxt;
  logic [COLS-1:0] f_idx [DEPTH];
  logic [TAG_W-1:0] tag, tag_nxt;
  logic [TAG_W-1:0] f_tag [DEPTH];
  logic zflag, zflag_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [OFF_W-1:0] hi;
  logic last, push, pop, hs, retire, nonempty;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    hi = '0;
    for (int i = 0; i < COLS; i++) hi = mask[i] ? OFF_W'(i) : hi;
  end

  assign last     = zflag | ~|(mask & (mask - 1'b1));
  assign nonempty = count != '0;
  assign in_ready = count < CW'(DEPTH);
  assign push     = in_valid & in_ready;
  assign hs       = state == RUN & out_ready;
  assign retire   = hs & last;
  assign pop      = nonempty & (state == IDLE | retire);
  assign busy     = state == RUN | nonempty;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      tag         <= '0;
      zflag       <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      stat_groups <= '0;
    end else begin
      state       <= state_nxt;
      mask        <= mask_nxt;
      tag         <= tag_nxt;
      zflag       <= zflag_nxt;
      rd_ptr      <= pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr      <= push ? inc(wr_ptr) : wr_ptr;
      count       <= count + CW'(push) - CW'(pop);
      stat_groups <= stat_groups + 16'(retire);
    end

  always_ff @(posedge clk)
    if (push) begin
      f_idx[wr_ptr] <= in_index;
      f_tag[wr_ptr] <= in_tag;
    end

  always_comb begin
    state_nxt = pop ? RUN : retire ? IDLE : state;
    mask_nxt  = pop ? f_idx[rd_ptr] : retire ? '0 : hs ? mask & ~(COLS'(1) << hi) : mask;
    tag_nxt   = pop ? f_tag[rd_ptr] : retire ? '0 : tag;
    zflag_nxt = pop ? f_idx[rd_ptr] == '0 : retire ? 1'b0 : zflag;
  end

  always_comb begin
    out_valid  = state == RUN;
    out_offset = out_valid && !zflag ? hi : '0;
    out_last   = out_valid & last;
    out_empty  = out_valid & zflag;
    out_tag    = out_valid ? tag : '0;
  end
endmodule

// File: tb/tb_bit_column_scheduler.sv
// tb_bit_column_scheduler: directed checks of beat order, backpressure, FIFO full, reset and counter wrap
module tb_bit_column_scheduler;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [6:0] in_index = '0;
  logic [3:0] in_tag = '0;
  logic in_ready, out_valid, out_last, out_empty, busy;
  logic [2:0] out_offset;
  logic [3:0] out_tag;
  logic [15:0] stat_groups;
  int n_chk = 0, n_fail = 0, pushed = 0, cycles = 0;
  logic saw_ffff = 1'b0;

  always #5 clk = ~clk;

  bit_column_scheduler #(.COLS(7), .OFF_W(3), .TAG_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_offset(out_offset),
    .out_last(out_last), .out_empty(out_empty), .out_tag(out_tag), .busy(busy),
    .stat_groups(stat_groups)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic beat(input string name, input logic v, input logic [2:0] off, input logic l,
                      input logic e, input logic [3:0] t);
    chk(name, {22'd0, out_valid, out_offset, out_last, out_empty, out_tag}, {22'd0, v, off, l, e, t});
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic push(input logic [6:0] idx, input logic [3:0] t);
    in_valid = 1'b1;
    in_index = idx;
    in_tag = t;
  endtask

  initial begin
    nxt;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_stat", stat_groups, 0);
    rst = 1'b0;
    push(7'b1010010, 4'd3);
    out_ready = 1'b1;
    nxt; in_valid = 1'b0; beat("t1_wait", 0, 0, 0, 0, 0);
    nxt; beat("t1_b0", 1, 6, 0, 0, 3);
    nxt; beat("t1_b1", 1, 4, 0, 0, 3);
    nxt; beat("t1_b2", 1, 1, 1, 0, 3); chk("t1_stat_pre", stat_groups, 0);
    nxt; beat("t1_idle", 0, 0, 0, 0, 0); chk("t1_stat", stat_groups, 1); chk("t1_busy", busy, 0);
    push(7'b0000000, 4'd5);
    nxt; in_valid = 1'b0; beat("t2_wait", 0, 0, 0, 0, 0);
    nxt; beat("t2_b0", 1, 0, 1, 1, 5);
    nxt; beat("t2_idle", 0, 0, 0, 0, 0); chk("t2_stat", stat_groups, 2);
    push(7'b0000001, 4'd1);
    nxt; chk("t3_ready", in_ready, 1); push(7'b1000000, 4'd2);
    nxt; in_valid = 1'b0; beat("t3_b0", 1, 0, 1, 0, 1);
    nxt; beat("t3_b1", 1, 6, 1, 0, 2);
    nxt; beat("t3_idle", 0, 0, 0, 0, 0); chk("t3_stat", stat_groups, 4);
    push(7'b0110000, 4'd7);
    nxt; in_valid = 1'b0;
    nxt; beat("t4_b0", 1, 5, 0, 0, 7); out_ready = 1'b0; push(7'b0000011, 4'd8);
    nxt; beat("t4_hold1", 1, 5, 0, 0, 7); chk("t4_ready1", in_ready, 1); push(7'b0001000, 4'd9);
    nxt; beat("t4_hold2", 1, 5, 0, 0, 7); chk("t4_full", in_ready, 0); push(7'b1000001, 4'd10);
    nxt; beat("t4_hold3", 1, 5, 0, 0, 7); chk("t4_refused", in_ready, 0); out_ready = 1'b1;
    nxt; beat("t4_b1", 1, 4, 1, 0, 7); chk("t4_refused2", in_ready, 0);
    nxt; beat("t4_a0", 1, 1, 0, 0, 8); chk("t4_ready2", in_ready, 1);
    nxt; in_valid = 1'b0; beat("t4_a1", 1, 0, 1, 0, 8); chk("t4_full2", in_ready, 0);
    nxt; beat("t4_b", 1, 3, 1, 0, 9);
    nxt; beat("t4_c0", 1, 6, 0, 0, 10);
    nxt; beat("t4_c1", 1, 0, 1, 0, 10);
    nxt; beat("t4_idle", 0, 0, 0, 0, 0); chk("t4_stat", stat_groups, 8); chk("t4_busy", busy, 0);
    push(7'b1111111, 4'd1);
    nxt; push(7'b0000001, 4'd2);
    nxt; beat("t5_b0", 1, 6, 0, 0, 1); push(7'b0000010, 4'd3);
    nxt; in_valid = 1'b0; beat("t5_b1", 1, 5, 0, 0, 1); chk("t5_busy_pre", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_stat", stat_groups, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_busy", busy, 0);
    push(7'b1111111, 4'd15);
    nxt; rst = 1'b0; push(7'b0000100, 4'd4);
    nxt; in_valid = 1'b0; beat("t5_wait", 0, 0, 0, 0, 0);
    nxt; beat("t5_n0", 1, 2, 1, 0, 4);
    nxt; beat("t5_idle", 0, 0, 0, 0, 0); chk("t5_stat", stat_groups, 1);
    while ((pushed < 65535 || busy) && cycles < 80000) begin
      in_valid = pushed < 65535;
      in_index = '0;
      in_tag = 4'hA;
      if (in_valid && in_ready) pushed++;
      nxt;
      cycles++;
      if (stat_groups == 16'hFFFF) saw_ffff = 1'b1;
    end
    in_valid = 1'b0;
    chk("t6_done", cycles < 80000, 1);
    chk("t6_saw_ffff", saw_ffff, 1);
    chk("t6_stat_wrap", stat_groups, 0);
    chk("t6_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_column_scheduler.md
# bit_column_scheduler

Sequences the bit-serial BCE datapath over the non-zero bit columns of each weight group. It accepts one per-group column index vector per handshake and buffers up to DEPTH vectors. For each group it emits one shift offset per cycle, highest non-zero column first, with backpressure. All-zero groups retire in a single flagged beat, so downstream accumulators never stall on an empty group. It sits between the index-generation stage and the BCE shift/accumulate array.

## Interface
- COLS, 7, number of bit columns per group (index vector width)
- OFF_W, 3, shift offset width; must satisfy 2^OFF_W >= COLS
- TAG_W, 4, group tag width, passed through unchanged
- DEPTH, 2, input FIFO depth (>= 1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  index vector offered
- in_ready  out  1  FIFO can accept; equals (fifo_count < DEPTH)
- in_index  in  COLS  bit i = 1 means bit column i of the group is non-zero
- in_tag  in  TAG_W  group identifier
- out_valid  out  1  beat available to BCE
- out_ready  in  1  BCE consumes beat
- out_offset  out  OFF_W  column index (shift amount) for this beat
- out_last  out  1  final beat of the current group
- out_empty  out  1  group had no non-zero columns; offset is 0 and must not be accumulated
- out_tag  out  TAG_W  tag of the current group
- busy  out  1  work register loaded or FIFO non-empty
- stat_groups  out  16  count of retired groups; wraps

## Operation
- Input FIFO: push on in_valid & in_ready. There is no fall-through and no bypass: when count == DEPTH, a push is refused even if a pop occurs on the same edge.
- Work register: holds mask[COLS-1:0], tag, zflag, and state (IDLE/RUN).
- IDLE: if the FIFO is non-empty, pop the head into the work register and go to RUN. zflag = (head index == 0).
- RUN outputs, combinational from the work register:
  - out_valid = 1
  - out_offset = position of the highest set bit of mask, or 0 if zflag
  - out_last = zflag or (mask has exactly one bit set)
  - out_empty = zflag
  - out_tag = tag
- Beat handshake is out_valid & out_ready. On a handshake:
  - if not last, clear the emitted bit of mask;
  - if last, retire the group, increment stat_groups, then:
    - if the FIFO is non-empty, pop and reload the work register on the same edge and stay in RUN (no bubble);
    - otherwise go to IDLE.
- No handshake: all outputs are held stable. The AXI-style rule applies: out_valid does not drop once asserted until its beat is accepted.
- Outputs in IDLE: out_valid = 0; out_offset, out_last, out_empty and out_tag = 0.
- stat_groups increments modulo 2^16 (0xFFFF -> 0x0000).
- Inputs are ignored while rst is high.

## Timing
- Reset (asynchronous, takes effect immediately):
  - FIFO emptied, state IDLE, mask/tag/zflag = 0, stat_groups = 0;
  - out_valid = 0, busy = 0, in_ready = 1 (count is 0).
- Latency, accept to first beat:
  - a vector accepted at edge E into an empty FIFO with the scheduler in IDLE loads at E+1;
  - out_valid is high in the cycle after E+1.
- Throughput:
  - a group with k non-zero columns occupies k beat cycles;
  - an all-zero group occupies 1 beat cycle;
  - back-to-back groups are contiguous when the FIFO is non-empty at the last beat.
- Pops occur on exactly two conditions: the IDLE load, and the last-beat handshake with the FIFO non-empty. Each pop frees a slot, so in_ready rises the cycle after that edge.
- Reset asserted mid-group discards the in-flight group and all buffered vectors. No partial out_last is produced.

## Test plan
- **Single group, full throughput.** Accept in_index=7'b1010010, tag=3, with out_ready=1 held high. Required: beats with offsets 6, 4, 1 on consecutive cycles. The first beat appears 2 edges after accept. out_last is set only on offset 1, out_tag=3 on all beats, and stat_groups goes 0->1.
- **All-zero group.** Accept in_index=0. Required: exactly one beat with offset=0, out_empty=1, out_last=1; stat_groups increments.
- **Back-to-back groups.** Accept 7'b0000001 (tag 1) then 7'b1000000 (tag 2) on consecutive cycles. Required: beat offset 0/last/tag 1 immediately followed by beat offset 6/last/tag 2, with no idle cycle between them.
- **Backpressure and FIFO full.** Drop out_ready for 3 cycles mid-group of 7'b0110000; the outputs must stay at offset 5 throughout. Meanwhile push two more vectors: in_ready must fall after the second accept, and a third in_valid must be refused until the group retires.
- **Reset mid-group.** Assert rst during the second beat of 7'b1111111 with 2 entries queued. Required: out_valid=0 and stat_groups=0 immediately, in_ready=1. After release, a new vector 7'b0000100 yields a single beat at offset 2.
- **Counter wrap.** Retire 65536 groups. Required: stat_groups reads 0 afterwards and has passed through 0xFFFF.
